// File: rtl/hazard_pkg.sv
// Shared scoreboard entry type and forwarding-select encodings for the hazard unit.
package hazard_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned REG_AW_MAX     = 8;
    localparam int unsigned DEPTH_DEFAULT  = 3;

    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned FWD_MEM = 1;
    localparam int unsigned FWD_WB  = DEPTH_DEFAULT - 1;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dest;
        logic                  wb_en;
        logic                  mem_r;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destinations (EXE..WB) with bubble insertion and
// per-entry source-match flags; the WB entry is tracked but never reported as a match.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT,
    parameter int unsigned DEPTH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    output logic [DEPTH-2:0]  match_a,
    output logic [DEPTH-2:0]  match_b,
    output logic              head_mem_r
);

    sb_entry_t entries [DEPTH];
    sb_entry_t new_entry;

    always_comb begin
        new_entry = '0;
        if (load_en) begin
            new_entry.valid = 1'b1;
            new_entry.dest  = REG_AW_MAX'(id_dest);
            new_entry.wb_en = id_wb_en;
            new_entry.mem_r = id_mem_r_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
        end else begin
            entries[0] <= new_entry;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

    // Register 0 is hard-wired, so it never creates a dependency.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            match_a[k] = entries[k].valid && entries[k].wb_en && (id_src1 != '0)
                         && (entries[k].dest == REG_AW_MAX'(id_src1));
            match_b[k] = entries[k].valid && entries[k].wb_en && (id_src2 != '0)
                         && id_src2_used && (entries[k].dest == REG_AW_MAX'(id_src2));
        end
    end

    assign head_mem_r = entries[0].mem_r;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding controller for the five-stage pipeline.
// Define FORWARDING_EN to forward non-load results; otherwise any hazard stalls until WB.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned SEL_W  = $clog2(DEPTH),
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-2:0] match_a;
    logic [DEPTH-2:0] match_b;
    logic             head_mem_r;
    logic             hazard;
    logic             load_en;

    hazard_scoreboard #(
        .REG_AW(REG_AW),
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_src2_used(id_src2_used),
        .match_a     (match_a),
        .match_b     (match_b),
        .head_mem_r  (head_mem_r)
    );

    assign flush = branch_taken;

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time.
    assign hazard = id_valid & (match_a[0] | match_b[0]) & head_mem_r;
`else
    logic unused_head_mem_r;
    assign unused_head_mem_r = head_mem_r;
    assign hazard = id_valid & (|{match_a, match_b});
`endif

    assign stall   = hazard & ~flush;
    assign load_en = id_valid & ~stall & ~flush;

`ifdef FORWARDING_EN
    logic [SEL_W-1:0] sel_a_d;
    logic [SEL_W-1:0] sel_b_d;

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        sel_a_d = SEL_W'(FWD_RF);
        sel_b_d = SEL_W'(FWD_RF);
        if (load_en) begin
            for (int k = DEPTH - 2; k >= 0; k--) begin
                if (match_a[k]) sel_a_d = SEL_W'(int'(FWD_MEM) + k);
                if (match_b[k]) sel_b_d = SEL_W'(int'(FWD_MEM) + k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel_a <= '0;
            fwd_sel_b <= '0;
        end else begin
            fwd_sel_a <= sel_a_d;
            fwd_sel_b <= sel_b_d;
        end
    end
`else
    assign fwd_sel_a = '0;
    assign fwd_sel_b = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with an instruction-level pipeline model; works with
// or without FORWARDING_EN.
module tb_hazard_unit;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned SEL_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 16;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_src1 = '0;
    logic [REG_AW-1:0] id_src2 = '0;
    logic              id_src2_used = 1'b0;
    logic [REG_AW-1:0] id_dest = '0;
    logic              id_wb_en = 1'b0;
    logic              id_mem_r_en = 1'b0;
    logic              branch_taken = 1'b0;
    logic              stall;
    logic              flush;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic [CNT_W-1:0]  stall_count;

    always #5 clk = ~clk;

    hazard_unit #(
        .REG_AW(REG_AW),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_src2_used(id_src2_used),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .branch_taken(branch_taken),
        .stall       (stall),
        .flush       (flush),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .stall_count (stall_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions by stage (0 = EXE .. DEPTH-1 = WB).
    bit mv [DEPTH];
    int md [DEPTH];
    bit mw [DEPTH];
    bit ml [DEPTH];
    int m_sel_a = 0;
    int m_sel_b = 0;
    int m_cnt   = 0;

    function automatic bit produces(input int k, input int src);
        return mv[k] && mw[k] && (md[k] == src) && (src != 0);
    endfunction

    function automatic bit depends(input int k);
        return produces(k, int'(id_src1)) || (id_src2_used && produces(k, int'(id_src2)));
    endfunction

    function automatic bit exp_stall();
        if (!id_valid || branch_taken) return 1'b0;
        if (FWD) return depends(0) && ml[0];
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (depends(k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit st;
        bit acc;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mv[k] = 1'b0; md[k] = 0; mw[k] = 1'b0; ml[k] = 1'b0;
            end
            m_sel_a = 0;
            m_sel_b = 0;
            m_cnt   = 0;
        end else begin
            st  = exp_stall();
            acc = id_valid && !st && !branch_taken;
            if (st && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            m_sel_a = 0;
            m_sel_b = 0;
            if (FWD && acc) begin
                // First hit from EXE outward is the youngest producer.
                for (int k = 0; k < DEPTH - 1; k++) begin
                    if (m_sel_a == 0 && produces(k, int'(id_src1))) m_sel_a = k + 1;
                    if (m_sel_b == 0 && id_src2_used && produces(k, int'(id_src2)))
                        m_sel_b = k + 1;
                end
            end
            for (int k = DEPTH - 1; k > 0; k--) begin
                mv[k] = mv[k-1]; md[k] = md[k-1]; mw[k] = mw[k-1]; ml[k] = ml[k-1];
            end
            mv[0] = acc;
            md[0] = int'(id_dest);
            mw[0] = id_wb_en;
            ml[0] = id_mem_r_en;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model stall", int'(stall), int'(exp_stall()));
            chk("model flush", int'(flush), int'(branch_taken));
            chk("model fwd_sel_a", int'(fwd_sel_a), m_sel_a);
            chk("model fwd_sel_b", int'(fwd_sel_b), m_sel_b);
            chk("model stall_count", int'(stall_count), m_cnt);
        end
    end

    task automatic drive(input bit v, input int s1, input int s2, input bit used, input int d,
                         input bit wb, input bit ld);
        id_valid     = v;
        id_src1      = REG_AW'(s1);
        id_src2      = REG_AW'(s2);
        id_src2_used = used;
        id_dest      = REG_AW'(d);
        id_wb_en     = wb;
        id_mem_r_en  = ld;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the instruction in ID until it advances; returns just after it enters EXE.
    task automatic issue(input string name, input int s1, input int s2, input bit used,
                         input int d, input bit ld, input int exp_stalls);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        drive(1'b1, s1, s2, used, d, 1'b1, ld);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        chk({name, " stall cycles"}, n, exp_stalls);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset stall", int'(stall), 0);
        chk("reset flush", int'(flush), 0);
        chk("reset fwd_sel_a", int'(fwd_sel_a), 0);
        chk("reset fwd_sel_b", int'(fwd_sel_b), 0);
        chk("reset stall_count", int'(stall_count), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Independent instructions
        issue("add r1", 10, 11, 1'b1, 1, 1'b0, 0);
        issue("add r2", 12, 13, 1'b1, 2, 1'b0, 0);
        @(negedge clk);
        chk("indep fwd_sel_a", int'(fwd_sel_a), 0);
        chk("indep fwd_sel_b", int'(fwd_sel_b), 0);
        chk("indep stall_count", int'(stall_count), 0);
        idle(3);

        // ALU result consumed immediately
        issue("add r3", 1, 2, 1'b1, 3, 1'b0, 0);
        issue("sub r4", 3, 5, 1'b1, 4, 1'b0, FWD ? 0 : 2);
        @(negedge clk);
        chk("alu fwd_sel_a", int'(fwd_sel_a), FWD ? 1 : 0);
        chk("alu fwd_sel_b", int'(fwd_sel_b), 0);
        chk("alu stall_count", int'(stall_count), FWD ? 0 : 2);
        idle(3);

        // Load-use
        issue("lw r6", 0, 0, 1'b0, 6, 1'b1, 0);
        issue("add r7", 6, 6, 1'b1, 7, 1'b0, FWD ? 1 : 2);
        @(negedge clk);
        chk("load fwd_sel_a", int'(fwd_sel_a), FWD ? 2 : 0);
        chk("load fwd_sel_b", int'(fwd_sel_b), FWD ? 2 : 0);
        chk("load stall_count", int'(stall_count), FWD ? 1 : 4);
        idle(3);

        // Register 0 never creates a hazard
        issue("add r0", 1, 2, 1'b1, 0, 1'b0, 0);
        issue("add r8", 0, 0, 1'b1, 8, 1'b0, 0);
        @(negedge clk);
        chk("r0 fwd_sel_a", int'(fwd_sel_a), 0);
        chk("r0 fwd_sel_b", int'(fwd_sel_b), 0);
        idle(3);

        // Branch taken while a load-use stall would fire
        issue("lw r9", 0, 0, 1'b0, 9, 1'b1, 0);
        drive(1'b1, 9, 9, 1'b1, 10, 1'b1, 1'b0);
        branch_taken = 1'b1;
        @(negedge clk);
        chk("branch flush", int'(flush), 1);
        chk("branch stall", int'(stall), 0);
        chk("branch stall_count", int'(stall_count), FWD ? 1 : 4);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        issue("add r12 after flush", 10, 13, 1'b1, 12, 1'b0, 0);
        @(negedge clk);
        chk("flush discard fwd_sel_a", int'(fwd_sel_a), 0);
        chk("flush discard fwd_sel_b", int'(fwd_sel_b), 0);
        idle(3);

        // Reset asserted in the middle of a dependency
        issue("add r3 again", 1, 2, 1'b1, 3, 1'b0, 0);
        drive(1'b1, 3, 5, 1'b1, 4, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre-reset stall", int'(stall), FWD ? 0 : 1);
        #1 rst = 1'b1;
        #1;
        chk("async reset stall", int'(stall), 0);
        chk("async reset stall_count", int'(stall_count), 0);
        chk("async reset fwd_sel_a", int'(fwd_sel_a), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        @(negedge clk);
        chk("post-reset stall_count", int'(stall_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
